// File: rtl/ibufds_rx_pkg.sv
// Shared types and helpers for the differential receiver filter.
package ibufds_rx_pkg;

  // Decoded state of one synchronised I/IB pair.
  typedef enum logic [1:0] {
    DS_INVALID,
    DS_ZERO,
    DS_ONE
  } diff_state_t;

  // Width of a counter that must hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Only the two complementary states are legal; equal legs or any X/Z fall to default.
  function automatic diff_state_t decode_pair(input logic i, input logic ib);
    case ({i, ib})
      2'b10:   return DS_ONE;
      2'b01:   return DS_ZERO;
      default: return DS_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/ibufds_rx_chan.sv
// One differential channel: 2-flop synchroniser, pair decoder, run-length filter
// and consecutive-invalid counter.
module ibufds_rx_chan
  import ibufds_rx_pkg::*;
#(
  parameter int unsigned FILT_DEPTH = 3,
  parameter int unsigned INV_LIMIT  = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_i,
  input  logic ib_i,
  output logic o_o,
  output logic valid_o,
  output logic inv_hit_o,
  output logic invalid_o
);

  localparam int unsigned CntW = cnt_width(FILT_DEPTH);
  localparam int unsigned InvW = cnt_width(INV_LIMIT);

  logic [1:0]      s1_q, s2_q;
  logic            cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [InvW-1:0] inv_q, inv_d;
  logic            o_q, o_d;
  logic            valid_q, valid_d;
  logic            seen_q, seen_d;
  diff_state_t     state;
  logic            is_valid;
  logic            v;

  // Two-stage synchroniser on both legs; reset leaves the pair decoding as invalid.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= 2'b00;
      s2_q <= 2'b00;
    end else begin
      s1_q <= {i_i, ib_i};
      s2_q <= s1_q;
    end
  end

  // Decode the synchronised sample and compute filter / invalid-run next state.
  always_comb begin
    state     = decode_pair(s2_q[1], s2_q[0]);
    is_valid  = (state != DS_INVALID);
    v         = (state == DS_ONE);
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    inv_d     = inv_q;
    o_d       = o_q;
    valid_d   = is_valid;
    // Power-up invalid samples are ignored until the pair has been seen legal once.
    seen_d    = seen_q | is_valid;
    invalid_o = ~is_valid & seen_q;
    inv_hit_o = 1'b0;
    if (is_valid) begin
      inv_d = '0;
      if (v != cand_q) begin
        cand_d = v;
        cnt_d  = CntW'(1);
      end else if (cnt_q != CntW'(FILT_DEPTH)) begin
        cnt_d = cnt_q + CntW'(1);
      end
      if (cnt_d == CntW'(FILT_DEPTH)) begin
        o_d = cand_d;
      end
    end else begin
      cnt_d = '0;
      if (seen_q) begin
        if (inv_q != InvW'(INV_LIMIT)) begin
          inv_d = inv_q + InvW'(1);
        end
        // Fires only on the edge where the run first reaches the limit.
        inv_hit_o = (inv_q == InvW'(INV_LIMIT - 1));
      end
    end
  end

  // Filter, invalid-run and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cand_q  <= 1'b0;
      cnt_q   <= '0;
      inv_q   <= '0;
      o_q     <= 1'b0;
      valid_q <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      o_q     <= o_d;
      valid_q <= valid_d;
      seen_q  <= seen_d;
    end
  end

  assign o_o     = o_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ibufds_rx_filt.sv
// Multi-channel filtered differential receiver with link error diagnostics.
module ibufds_rx_filt
  import ibufds_rx_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned FILT_DEPTH = 3,
  parameter int unsigned INV_LIMIT  = 4,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [WIDTH-1:0]     I,
  input  logic [WIDTH-1:0]     IB,
  input  logic                 CLR_ERR,
  output logic [WIDTH-1:0]     O,
  output logic [WIDTH-1:0]     OB,
  output logic [WIDTH-1:0]     VALID,
  output logic                 ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  logic [WIDTH-1:0]     inv_hit;
  logic [WIDTH-1:0]     invalid;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    ibufds_rx_chan #(
      .FILT_DEPTH (FILT_DEPTH),
      .INV_LIMIT  (INV_LIMIT)
    ) u_chan (
      .clk_i     (CLK),
      .rst_ni    (RST_N),
      .i_i       (I[g]),
      .ib_i      (IB[g]),
      .o_o       (O[g]),
      .valid_o   (VALID[g]),
      .inv_hit_o (inv_hit[g]),
      .invalid_o (invalid[g])
    );
  end

  // Sticky error flag and per-cycle saturating invalid counter; clear wins over events.
  always_comb begin
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (CLR_ERR) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end else begin
      if (|inv_hit) begin
        err_d = 1'b1;
      end
      if ((|invalid) && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  // Diagnostic registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign OB      = ~O;
  assign ERR     = err_q;
  assign ERR_CNT = err_cnt_q;

endmodule
